// File: rtl/stopwatch_ctrl.sv
// Stopwatch button controller: edge-detects start/stop and lap/reset buttons,
// drives one-cycle stopwatch commands and buffers lap captures in a FWFT FIFO.
module stopwatch_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LAP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_ss,
  input  logic                  btn_lr,
  input  logic [DATA_WIDTH-1:0] sw_count,
  output logic                  sw_start,
  output logic                  sw_stop,
  output logic                  sw_reset,
  output logic [DATA_WIDTH-1:0] lap_data,
  output logic                  lap_valid,
  input  logic                  lap_ready,
  output logic                  lap_overflow,
  output logic [1:0]            state
);

  localparam int unsigned AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic ss_prev, lr_prev;
  logic ss_rise, lr_rise;
  logic start_d, stop_d, rst_cmd_d;
  logic push_req, flush;

  logic [DATA_WIDTH-1:0] mem [LAP_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  full, pop, push_ok;

  assign ss_rise = btn_ss & ~ss_prev;
  assign lr_rise = btn_lr & ~lr_prev;

  assign full    = (count == CW'(LAP_DEPTH));
  assign pop     = lap_valid & lap_ready;
  assign push_ok = push_req & (~full | pop);

  assign lap_valid = (count != '0);
  assign lap_data  = mem[rd_ptr];
  assign state     = state_q;

  // Next-state and command decode; ss has priority over lr.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    rst_cmd_d = 1'b0;
    push_req  = 1'b0;
    flush     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_rise) begin
          start_d = 1'b1;
          state_d = RUN;
        end else if (lr_rise) begin
          rst_cmd_d = 1'b1;
        end
      end
      RUN: begin
        if (ss_rise) begin
          stop_d  = 1'b1;
          state_d = PAUSE;
        end else if (lr_rise) begin
          push_req = 1'b1;
        end
      end
      PAUSE: begin
        if (ss_rise) begin
          start_d = 1'b1;
          state_d = RUN;
        end else if (lr_rise) begin
          rst_cmd_d = 1'b1;
          flush     = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Button history loads the live level during reset so a held button is not a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sw_start     <= 1'b0;
      sw_stop      <= 1'b0;
      sw_reset     <= 1'b0;
      ss_prev      <= btn_ss;
      lr_prev      <= btn_lr;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      lap_overflow <= 1'b0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sw_start <= start_d;
      sw_stop  <= stop_d;
      sw_reset <= rst_cmd_d;
      ss_prev  <= btn_ss;
      lr_prev  <= btn_lr;
      if (flush) begin
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
        lap_overflow <= 1'b0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= sw_count;
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push_ok && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push_ok) begin
          count <= count - CW'(1);
        end
        if (push_req && full && !pop) begin
          lap_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus queues expected commands, laps
// and per-cycle snapshots; a negedge monitor compares them against the outputs.
module tb_stopwatch_ctrl;

  localparam logic [2:0] C_START = 3'b100;
  localparam logic [2:0] C_STOP  = 3'b010;
  localparam logic [2:0] C_RESET = 3'b001;

  typedef struct {
    logic [2:0] cmd;
    logic [1:0] st;
  } cmd_t;

  typedef struct {
    int          at;
    int          kind;
    logic [1:0]  st;
    logic [2:0]  cmd;
    logic        valid;
    logic        ovf;
    logic        dchk;
    logic [15:0] data;
  } snap_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_ss, btn_lr;
  logic [15:0] sw_count;
  logic        sw_start, sw_stop, sw_reset;
  logic [15:0] lap_data;
  logic        lap_valid, lap_ready, lap_overflow;
  logic [1:0]  state;

  cmd_t        cmd_q  [$];
  logic [15:0] lap_q  [$];
  snap_t       snap_q [$];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  stopwatch_ctrl #(.DATA_WIDTH(16), .LAP_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_ss       (btn_ss),
    .btn_lr       (btn_lr),
    .sw_count     (sw_count),
    .sw_start     (sw_start),
    .sw_stop      (sw_stop),
    .sw_reset     (sw_reset),
    .lap_data     (lap_data),
    .lap_valid    (lap_valid),
    .lap_ready    (lap_ready),
    .lap_overflow (lap_overflow),
    .state        (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT presents a command, a lap handshake or a due snapshot.
  always @(negedge clk) begin
    logic [2:0]  c;
    cmd_t        e;
    snap_t       s;
    logic [15:0] d;
    c = {sw_start, sw_stop, sw_reset};
    if (!reset) begin
      if (c != 3'b000) begin
        n_cmp++;
        if (cmd_q.size() == 0) begin
          n_bad++;
          $display("FAIL cmd_unexpected: got cmd=%b state=%0d, required no command (cyc %0d)", c, state, cyc);
        end else begin
          e = cmd_q.pop_front();
          if (c !== e.cmd || state !== e.st) begin
            n_bad++;
            $display("FAIL cmd: got cmd=%b state=%0d, required cmd=%b state=%0d (cyc %0d)", c, state, e.cmd, e.st, cyc);
          end
        end
      end
      if (lap_valid && lap_ready) begin
        n_cmp++;
        if (lap_q.size() == 0) begin
          n_bad++;
          $display("FAIL lap_unexpected: got lap_data=%h, required no lap (cyc %0d)", lap_data, cyc);
        end else begin
          d = lap_q.pop_front();
          if (lap_data !== d) begin
            n_bad++;
            $display("FAIL lap_data: got %h, required %h (cyc %0d)", lap_data, d, cyc);
          end
        end
      end
    end
    while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
      s = snap_q.pop_front();
      n_cmp++;
      if (s.kind == 1) begin
        if (state !== s.st || c !== s.cmd) begin
          n_bad++;
          $display("FAIL ctl: got state=%0d cmd=%b, required state=%0d cmd=%b (cyc %0d)", state, c, s.st, s.cmd, cyc);
        end
      end else if (s.kind == 2) begin
        if (lap_valid !== s.valid || lap_overflow !== s.ovf || (s.dchk && lap_data !== s.data)) begin
          n_bad++;
          $display("FAIL fifo: got valid=%b ovf=%b data=%h, required valid=%b ovf=%b data=%h (cyc %0d)",
                   lap_valid, lap_overflow, lap_data, s.valid, s.ovf, s.data, cyc);
        end
      end else begin
        if (cmd_q.size() != 0 || lap_q.size() != 0) begin
          n_bad++;
          $display("FAIL leftover: got %0d cmds %0d laps outstanding, required 0 and 0", cmd_q.size(), lap_q.size());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ctl(input logic [1:0] st, input logic [2:0] cmd);
    snap_t s;
    s = '{default: '0};
    s.at = cyc; s.kind = 1; s.st = st; s.cmd = cmd;
    snap_q.push_back(s);
  endtask

  task automatic exp_fifo(input logic valid, input logic ovf, input logic dchk, input logic [15:0] data);
    snap_t s;
    s = '{default: '0};
    s.at = cyc; s.kind = 2; s.valid = valid; s.ovf = ovf; s.dchk = dchk; s.data = data;
    snap_q.push_back(s);
  endtask

  // One-cycle button press followed by one cycle released; checks pulse in k+1 and its end in k+2.
  task automatic press(input logic ss, input logic lr, input logic [2:0] cmd, input logic [1:0] st);
    cmd_t e;
    btn_ss = ss;
    btn_lr = lr;
    if (cmd != 3'b000) begin
      e.cmd = cmd; e.st = st;
      cmd_q.push_back(e);
    end
    tick();
    exp_ctl(st, cmd);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    tick();
    exp_ctl(st, 3'b000);
  endtask

  task automatic lap(input logic [15:0] v, input logic kept);
    sw_count = v;
    if (kept) lap_q.push_back(v);
    press(1'b0, 1'b1, 3'b000, 2'd1);
  endtask

  task automatic drain(input logic ovf);
    lap_ready = 1'b1;
    for (int i = 0; i < 20 && lap_valid; i++) tick();
    lap_ready = 1'b0;
    exp_fifo(1'b0, ovf, 1'b0, 16'h0);
    tick();
  endtask

  initial begin
    snap_t s;
    cmd_t  e;
    reset     = 1'b1;
    btn_ss    = 1'b1;
    btn_lr    = 1'b0;
    sw_count  = 16'h0;
    lap_ready = 1'b0;

    // Reset with start/stop held through release: no start until a fresh 0->1.
    tick();
    exp_ctl(2'd0, 3'b000);
    exp_fifo(1'b0, 1'b0, 1'b1, 16'h0);
    tick();
    reset = 1'b0;
    tick();
    exp_ctl(2'd0, 3'b000);
    tick();
    exp_ctl(2'd0, 3'b000);
    btn_ss = 1'b0;
    tick();
    tick();
    press(1'b1, 1'b0, C_START, 2'd1);

    // Three laps queued, then drained in order.
    lap(16'h0005, 1'b1);
    lap(16'h0009, 1'b1);
    lap(16'h000C, 1'b1);
    exp_fifo(1'b1, 1'b0, 1'b1, 16'h0005);
    drain(1'b0);

    // Full FIFO with simultaneous push and pop keeps occupancy, no overflow.
    lap(16'h0021, 1'b1);
    lap(16'h0022, 1'b1);
    lap(16'h0023, 1'b1);
    lap(16'h0024, 1'b1);
    sw_count  = 16'h0025;
    lap_q.push_back(16'h0025);
    btn_lr    = 1'b1;
    lap_ready = 1'b1;
    tick();
    lap_ready = 1'b0;
    btn_lr    = 1'b0;
    tick();
    exp_fifo(1'b1, 1'b0, 1'b1, 16'h0022);
    drain(1'b0);

    // Five laps into a depth-4 FIFO: fifth dropped, overflow sticky.
    lap(16'h0011, 1'b1);
    lap(16'h0012, 1'b1);
    lap(16'h0013, 1'b1);
    lap(16'h0014, 1'b1);
    exp_fifo(1'b1, 1'b0, 1'b1, 16'h0011);
    lap(16'h0015, 1'b0);
    exp_fifo(1'b1, 1'b1, 1'b1, 16'h0011);
    drain(1'b1);

    // Same-cycle ss and lr in RUN: stop wins, nothing pushed.
    sw_count = 16'h0033;
    press(1'b1, 1'b1, C_STOP, 2'd2);
    exp_fifo(1'b0, 1'b1, 1'b0, 16'h0);

    // PAUSE with two laps and overflow set: lr resets, flushes and clears overflow.
    press(1'b1, 1'b0, C_START, 2'd1);
    lap(16'h0031, 1'b1);
    lap(16'h0032, 1'b1);
    press(1'b1, 1'b0, C_STOP, 2'd2);
    exp_fifo(1'b1, 1'b1, 1'b1, 16'h0031);
    lap_q.delete();
    press(1'b0, 1'b1, C_RESET, 2'd0);
    exp_fifo(1'b0, 1'b0, 1'b0, 16'h0);

    // Held lr in IDLE: exactly one sw_reset, state stays IDLE.
    btn_lr = 1'b1;
    e.cmd = C_RESET; e.st = 2'd0;
    cmd_q.push_back(e);
    tick();
    exp_ctl(2'd0, C_RESET);
    tick();
    exp_ctl(2'd0, 3'b000);
    tick();
    tick();
    btn_lr = 1'b0;
    tick();

    // Reset mid-RUN overrides a same-cycle ss rise; no pulse afterwards.
    press(1'b1, 1'b0, C_START, 2'd1);
    reset  = 1'b1;
    btn_ss = 1'b1;
    tick();
    exp_ctl(2'd0, 3'b000);
    exp_fifo(1'b0, 1'b0, 1'b1, 16'h0);
    reset = 1'b0;
    tick();
    exp_ctl(2'd0, 3'b000);
    tick();
    exp_ctl(2'd0, 3'b000);
    btn_ss = 1'b0;
    tick();

    s = '{default: '0};
    s.at = cyc; s.kind = 3;
    snap_q.push_back(s);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
